// File: rtl/mem_fill_arbiter.sv
// Unified-memory arbiter for I/D cache line fills with dirty-victim writeback.
// One transaction at a time; fill line returned with a per-side done pulse.
module mem_fill_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int LINE_W  = 64,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wb_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [LINE_W-1:0] fill_data,
  output logic              i_done,
  output logic              d_done,
  output logic              busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_DFILL,
    S_IFILL,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              side_d_q, side_d_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [LINE_W-1:0] wdat_q, wdat_d;
  logic [LINE_W-1:0] fill_q, fill_d;
  logic              gnt_d, gnt_i;

  // last_d_q starts set so the first tie after reset is given to I.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_d_q <= 1'b1;
      side_d_q <= 1'b0;
      fa_q     <= '0;
      wa_q     <= '0;
      wdat_q   <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_d_q <= last_d_d;
      side_d_q <= side_d_d;
      fa_q     <= fa_d;
      wa_q     <= wa_d;
      wdat_q   <= wdat_d;
      fill_q   <= fill_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    side_d_d  = side_d_q;
    fa_d      = fa_q;
    wa_d      = wa_q;
    wdat_d    = wdat_q;
    fill_d    = fill_q;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    gnt_d     = d_req & (~i_req | ~last_d_q);
    gnt_i     = i_req & ~gnt_d;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_d) begin
          side_d_d = 1'b1;
          last_d_d = 1'b1;
          fa_d     = d_addr;
          wa_d     = d_wb_addr;
          wdat_d   = d_wb_data;
          cnt_d    = LAT_M1;
          state_d  = d_wb ? S_WB : S_DFILL;
        end else if (gnt_i) begin
          side_d_d = 1'b0;
          last_d_d = 1'b0;
          fa_d     = i_addr;
          cnt_d    = LAT_M1;
          state_d  = S_IFILL;
        end
      end
      S_WB: begin
        mem_we    = 1'b1;
        mem_addr  = wa_q;
        mem_wdata = wdat_q;
        if (cnt_q == '0) begin
          cnt_d   = LAT_M1;
          state_d = S_DFILL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DFILL, S_IFILL: begin
        mem_re   = 1'b1;
        mem_addr = fa_q;
        if (cnt_q == '0) begin
          fill_d  = mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        i_done  = ~side_d_q;
        d_done  = side_d_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fill_data = fill_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with MEM_LAT=4.
// Memory model returns {4{addr,2'b00}} while mem_re is high.
module tb_mem_fill_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [13:0] i_addr;
  logic        d_req;
  logic        d_wb;
  logic [13:0] d_addr;
  logic [13:0] d_wb_addr;
  logic [63:0] d_wb_data;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [63:0] fill_data;
  logic        i_done;
  logic        d_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [18:0] obs;
  logic [18:0] exp;

  mem_fill_arbiter #(
    .ADDR_W (14),
    .LINE_W (64),
    .MEM_LAT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .d_req    (d_req),
    .d_wb     (d_wb),
    .d_addr   (d_addr),
    .d_wb_addr(d_wb_addr),
    .d_wb_data(d_wb_data),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .fill_data(fill_data),
    .i_done   (i_done),
    .d_done   (d_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_re ? {4{mem_addr, 2'b00}} : 64'h0;
  assign obs = {mem_re, mem_we, mem_addr, i_done, d_done, busy};

  function automatic logic [63:0] line_of(input logic [13:0] a);
    return {4{a, 2'b00}};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_wb = 0;
    d_addr = 0; d_wb_addr = 0; d_wb_data = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (obs !== 19'h0 || fill_data !== 64'h0 || mem_wdata !== 64'h0) begin
      bad++;
      $display("FAIL reset got=%h fill=%h wd=%h exp=0", obs, fill_data, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 19'h0) begin
      bad++;
      $display("FAIL reset_rel got=%h exp=0", obs);
    end
  endtask

  task automatic test_i_fill();
    i_req = 1'b1;
    i_addr = 14'h0123;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) exp = {1'b1, 1'b0, 14'h0123, 1'b0, 1'b0, 1'b1};
      else if (c == 5) exp = {1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 1'b1};
      else exp = 19'h0;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL ifill c%0d got=%h exp=%h", c, obs, exp);
      end
      if (c == 5) begin
        total++;
        if (fill_data !== 64'h048C_048C_048C_048C) begin
          bad++;
          $display("FAIL ifill_data got=%h exp=048c048c048c048c", fill_data);
        end
        i_req = 1'b0;
      end
    end
  endtask

  // Latched inputs are scrambled and d_req dropped after grant.
  task automatic test_wb_fill();
    d_req = 1'b1;
    d_wb = 1'b1;
    d_wb_addr = 14'h0040;
    d_wb_data = 64'hDEAD_BEEF_0BAD_F00D;
    d_addr = 14'h0080;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 4) exp = {1'b0, 1'b1, 14'h0040, 1'b0, 1'b0, 1'b1};
      else if (c <= 8) exp = {1'b1, 1'b0, 14'h0080, 1'b0, 1'b0, 1'b1};
      else if (c == 9) exp = {1'b0, 1'b0, 14'h0, 1'b0, 1'b1, 1'b1};
      else exp = 19'h0;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL wbfill c%0d got=%h exp=%h", c, obs, exp);
      end
      if (c <= 4) begin
        total++;
        if (mem_wdata !== 64'hDEAD_BEEF_0BAD_F00D) begin
          bad++;
          $display("FAIL wb_wdata c%0d got=%h exp=deadbeef0badf00d", c, mem_wdata);
        end
      end
      if (c == 9) begin
        total++;
        if (fill_data !== 64'h0200_0200_0200_0200) begin
          bad++;
          $display("FAIL wb_fill_data got=%h exp=0200020002000200", fill_data);
        end
      end
      if (c == 1) begin
        d_wb_addr = 14'h3FFF;
        d_wb_data = 64'h0;
        d_addr = 14'h1111;
        d_wb = 1'b0;
      end
      if (c == 2) d_req = 1'b0;
    end
  endtask

  task automatic test_tie();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b1; i_addr = 14'h0AAA;
    d_req = 1'b1; d_addr = 14'h0555; d_wb = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c <= 4) exp = {1'b1, 1'b0, 14'h0AAA, 1'b0, 1'b0, 1'b1};
      else if (c == 5) exp = {1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 1'b1};
      else if (c == 6) exp = 19'h0;
      else if (c <= 10) exp = {1'b1, 1'b0, 14'h0555, 1'b0, 1'b0, 1'b1};
      else exp = {1'b0, 1'b0, 14'h0, 1'b0, 1'b1, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL tie c%0d got=%h exp=%h", c, obs, exp);
      end
    end
    total++;
    if (fill_data !== line_of(14'h0555)) begin
      bad++;
      $display("FAIL tie_data got=%h exp=%h", fill_data, line_of(14'h0555));
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // Previous transaction served D, so the sequence starts with I.
  task automatic test_starve();
    logic [13:0] ia, da, cur;
    logic        sd;
    @(negedge clk);
    ia = 14'h0100;
    da = 14'h0200;
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_addr = da; d_wb = 1'b0;
    for (int t = 0; t < 6; t++) begin
      sd = (t % 2) == 1;
      cur = sd ? da : ia;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c <= 4) exp = {1'b1, 1'b0, cur, 1'b0, 1'b0, 1'b1};
        else if (c == 5) exp = {1'b0, 1'b0, 14'h0, ~sd, sd, 1'b1};
        else exp = 19'h0;
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL starve t%0d c%0d got=%h exp=%h", t, c, obs, exp);
        end
        if (c == 5) begin
          total++;
          if (fill_data !== line_of(cur)) begin
            bad++;
            $display("FAIL starve_data t%0d got=%h exp=%h", t, fill_data, line_of(cur));
          end
          if (sd) begin
            da = da + 14'h0011;
            d_addr = da;
          end else begin
            ia = ia + 14'h0011;
            i_addr = ia;
          end
        end
        if (t == 5 && c == 6) begin
          i_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_req = 1'b1;
    d_wb = 1'b1;
    d_wb_addr = 14'h0777;
    d_wb_data = 64'h1122_3344_5566_7788;
    d_addr = 14'h0999;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      exp = {1'b0, 1'b1, 14'h0777, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rmid_pre c%0d got=%h exp=%h", c, obs, exp);
      end
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (obs !== 19'h0 || fill_data !== 64'h0) begin
      bad++;
      $display("FAIL rmid_async got=%h fill=%h exp=0", obs, fill_data);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (obs !== 19'h0) begin
        bad++;
        $display("FAIL rmid_hold c%0d got=%h exp=0", c, obs);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 4) exp = {1'b0, 1'b1, 14'h0777, 1'b0, 1'b0, 1'b1};
      else if (c <= 8) exp = {1'b1, 1'b0, 14'h0999, 1'b0, 1'b0, 1'b1};
      else if (c == 9) exp = {1'b0, 1'b0, 14'h0, 1'b0, 1'b1, 1'b1};
      else exp = 19'h0;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rmid_post c%0d got=%h exp=%h", c, obs, exp);
      end
      if (c <= 4) begin
        total++;
        if (mem_wdata !== 64'h1122_3344_5566_7788) begin
          bad++;
          $display("FAIL rmid_wdata c%0d got=%h exp=1122334455667788", c, mem_wdata);
        end
      end
      if (c == 9) begin
        total++;
        if (fill_data !== line_of(14'h0999)) begin
          bad++;
          $display("FAIL rmid_data got=%h exp=%h", fill_data, line_of(14'h0999));
        end
        d_req = 1'b0;
        d_wb = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_wb_fill();
    test_tie();
    test_starve();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
